// File: rtl/writeback_queue.sv
// In-order write-back FIFO feeding the register file's single write port, with
// forwarding of still-queued results to the decode read addresses.
module writeback_queue #(
    parameter int DEPTH             = 4,
    parameter int LOG_DEPTH         = 2,
    parameter int LOG_NUM_REGISTERS = 3,
    parameter int WIDTH             = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [LOG_NUM_REGISTERS-1:0] alu_addr,
    input  logic [WIDTH-1:0]             alu_data,
    output logic                         alu_ready,
    input  logic                         mem_valid,
    input  logic [LOG_NUM_REGISTERS-1:0] mem_addr,
    input  logic [WIDTH-1:0]             mem_data,
    output logic                         mem_ready,
    input  logic                         wb_hold,
    output logic                         writeEnable,
    output logic [LOG_NUM_REGISTERS-1:0] writeAddr,
    output logic [WIDTH-1:0]             d,
    input  logic [LOG_NUM_REGISTERS-1:0] ra,
    input  logic [LOG_NUM_REGISTERS-1:0] rb,
    output logic                         fwd_a_hit,
    output logic [WIDTH-1:0]             fwd_a_data,
    output logic                         fwd_b_hit,
    output logic [WIDTH-1:0]             fwd_b_data
);

    localparam logic [LOG_DEPTH:0] DEPTH_W = (LOG_DEPTH+1)'(DEPTH);

    logic [LOG_NUM_REGISTERS-1:0] addr_mem_r [DEPTH];
    logic [WIDTH-1:0]             data_mem_r [DEPTH];
    logic [LOG_DEPTH-1:0]         rd_ptr_r;
    logic [LOG_DEPTH-1:0]         wr_ptr_r;
    logic [LOG_DEPTH:0]           count_r;

    logic [LOG_DEPTH:0]           free_s;
    logic                         alu_push_s;
    logic                         mem_push_s;
    logic                         pop_s;
    logic [1:0]                   push_cnt_s;
    logic [LOG_DEPTH-1:0]         mem_idx_s;
    logic [LOG_DEPTH:0]           count_next_s;
    logic [WIDTH:0]               fwd_a_s;
    logic [WIDTH:0]               fwd_b_s;

    // Scan live entries oldest to youngest so the youngest match overrides; {hit, data}.
    function automatic logic [WIDTH:0] fwd_lookup(input logic [LOG_NUM_REGISTERS-1:0] raddr);
        logic [WIDTH:0]       res;
        logic [LOG_DEPTH-1:0] idx;
        res = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_r + LOG_DEPTH'(i);
            res = (((LOG_DEPTH+1)'(i) < count_r) && (addr_mem_r[idx] == raddr)) ?
                  {1'b1, data_mem_r[idx]} : res;
        end
        return res;
    endfunction

    // Flow control from registered occupancy only; a same-cycle pop never frees a slot.
    always_comb begin
        free_s       = DEPTH_W - count_r;
        alu_ready    = (free_s >= (LOG_DEPTH+1)'(1));
        mem_ready    = (free_s >= (LOG_DEPTH+1)'(2)) ||
                       ((free_s == (LOG_DEPTH+1)'(1)) && !alu_valid);
        alu_push_s   = alu_valid && alu_ready;
        mem_push_s   = mem_valid && mem_ready;
        push_cnt_s   = {1'b0, alu_push_s} + {1'b0, mem_push_s};
        mem_idx_s    = alu_push_s ? (wr_ptr_r + LOG_DEPTH'(1)) : wr_ptr_r;
        pop_s        = (count_r != '0) && !wb_hold;
        count_next_s = count_r + (LOG_DEPTH+1)'(push_cnt_s) - (LOG_DEPTH+1)'(pop_s);
    end

    // Head of queue drives the register file write port directly.
    always_comb begin
        writeEnable = pop_s;
        writeAddr   = addr_mem_r[rd_ptr_r];
        d           = data_mem_r[rd_ptr_r];
    end

    // Forwarding for both decode read ports.
    always_comb begin
        fwd_a_s    = fwd_lookup(ra);
        fwd_b_s    = fwd_lookup(rb);
        fwd_a_hit  = fwd_a_s[WIDTH];
        fwd_a_data = fwd_a_s[WIDTH-1:0];
        fwd_b_hit  = fwd_b_s[WIDTH];
        fwd_b_data = fwd_b_s[WIDTH-1:0];
    end

    // Queue storage and pointers; the ALU entry is older when both producers push.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= '0;
                data_mem_r[i] <= '0;
            end
        end else begin
            if (alu_push_s) begin
                addr_mem_r[wr_ptr_r] <= alu_addr;
                data_mem_r[wr_ptr_r] <= alu_data;
            end
            if (mem_push_s) begin
                addr_mem_r[mem_idx_s] <= mem_addr;
                data_mem_r[mem_idx_s] <= mem_data;
            end
            wr_ptr_r <= wr_ptr_r + LOG_DEPTH'(push_cnt_s);
            rd_ptr_r <= rd_ptr_r + LOG_DEPTH'(pop_s);
            count_r  <= count_next_s;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every register-file write the DUT presents.
module tb_writeback_queue;

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, wb_hold;
    logic [2:0]  alu_addr, mem_addr, ra, rb;
    logic [15:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, writeEnable, fwd_a_hit, fwd_b_hit;
    logic [2:0]  writeAddr;
    logic [15:0] d, fwd_a_data, fwd_b_data;

    int   errors = 0;
    int   checks = 0;
    int   mcount = 0;
    ent_t exp_q[$];
    logic [15:0] rf_exp [8];
    logic [15:0] rf_act [8];

    writeback_queue dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .wb_hold(wb_hold), .writeEnable(writeEnable), .writeAddr(writeAddr), .d(d),
        .ra(ra), .rb(rb),
        .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data),
        .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every presented write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && writeEnable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", writeAddr, d);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                if (writeAddr !== e.a || d !== e.d) begin
                    errors++;
                    $display("FAIL write_order: got r%0d=%0h expected r%0d=%0h", writeAddr, d, e.a, e.d);
                end
                rf_exp[e.a] = e.d;
                rf_act[writeAddr] = d;
            end
        end
    end

    int a_ok, m_ok, pop_m;

    // Drive one cycle's inputs; the model decides which pushes the queue accepts.
    task automatic set_in(input logic h, input logic av, input logic [2:0] aa, input logic [15:0] ad,
                          input logic mv, input logic [2:0] ma, input logic [15:0] md);
        int fr;
        wb_hold = h; alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        fr    = 4 - mcount;
        a_ok  = (av && fr >= 1) ? 1 : 0;
        m_ok  = (mv && (fr >= 2 || (fr == 1 && !av))) ? 1 : 0;
        pop_m = (mcount != 0 && !h) ? 1 : 0;
        if (a_ok == 1) exp_q.push_back('{a: aa, d: ad});
        if (m_ok == 1) exp_q.push_back('{a: ma, d: md});
    endtask

    task automatic idle(input logic h);
        set_in(h, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    endtask

    // Mid-cycle ready check against the model's occupancy.
    task automatic mid();
        int fr;
        @(negedge clk);
        fr = 4 - mcount;
        chk("alu_ready", {31'd0, alu_ready}, (fr >= 1) ? 32'd1 : 32'd0);
        chk("mem_ready", {31'd0, mem_ready}, (fr >= 2 || (fr == 1 && !alu_valid)) ? 32'd1 : 32'd0);
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
        mcount = mcount + a_ok + m_ok - pop_m;
    endtask

    logic       t_h  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       t_av [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [2:0] t_aa [8] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0};
    logic [15:0] t_ad [8] = '{16'h1000, 16'h1002, 16'h0000, 16'h1004, 16'h1006, 16'h1007, 16'h0000, 16'h100a};
    logic       t_mv [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] t_ma [8] = '{3'd5, 3'd0, 3'd7, 3'd3, 3'd0, 3'd1, 3'd4, 3'd2};
    logic [15:0] t_md [8] = '{16'h1001, 16'h0000, 16'h1003, 16'h1005, 16'h0000, 16'h1008, 16'h1009, 16'h100b};

    initial begin
        for (int i = 0; i < 8; i++) begin
            rf_exp[i] = 16'h0000;
            rf_act[i] = 16'h0000;
        end
        reset = 1'b1; ra = 3'd0; rb = 3'd0;
        idle(1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; mcount = 0; a_ok = 0; m_ok = 0; pop_m = 0;

        // Reset state
        idle(1'b0); mid();
        chk("rst_we", {31'd0, writeEnable}, 32'd0);
        chk("rst_addr", {29'd0, writeAddr}, 32'd0);
        chk("rst_d", {16'd0, d}, 32'd0);
        chk("rst_hits", {30'd0, fwd_a_hit, fwd_b_hit}, 32'd0);
        end_cycle();

        // Single ALU push: one-cycle write and forwarding of the head
        set_in(1'b0, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0000); mid(); end_cycle();
        idle(1'b0); ra = 3'd3; rb = 3'd2; mid();
        chk("t2_we", {31'd0, writeEnable}, 32'd1);
        chk("t2_addr", {29'd0, writeAddr}, 32'd3);
        chk("t2_d", {16'd0, d}, 32'h1234);
        chk("t2_fwd_a", {15'd0, fwd_a_hit, fwd_a_data}, 32'h11234);
        chk("t2_fwd_b_miss", {15'd0, fwd_b_hit, fwd_b_data}, 32'h0);
        end_cycle();
        idle(1'b0); mid();
        chk("t2_we_off", {31'd0, writeEnable}, 32'd0);
        chk("t2_fwd_gone", {31'd0, fwd_a_hit}, 32'd0);
        end_cycle();

        // Dual push to the same register: youngest (MEM) forwards
        set_in(1'b1, 1'b1, 3'd1, 16'h0001, 1'b1, 3'd1, 16'h0002); mid(); end_cycle();
        idle(1'b1); ra = 3'd1; rb = 3'd1; mid();
        chk("t3_fwd_a", {15'd0, fwd_a_hit, fwd_a_data}, 32'h10002);
        chk("t3_fwd_b", {15'd0, fwd_b_hit, fwd_b_data}, 32'h10002);
        chk("t3_held", {31'd0, writeEnable}, 32'd0);
        end_cycle();
        idle(1'b0); mid(); chk("t3_first", {16'd0, d}, 32'h0001); end_cycle();
        idle(1'b0); mid(); chk("t3_second", {16'd0, d}, 32'h0002); end_cycle();

        // Fill under hold: readiness boundaries
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 3'(4 + i), 16'h00a0 + 16'(i), 1'b0, 3'd0, 16'h0000); mid(); end_cycle();
        end
        idle(1'b1); mid();
        chk("t4_mem_rdy_free1", {31'd0, mem_ready}, 32'd1);
        end_cycle();
        set_in(1'b1, 1'b1, 3'd7, 16'h00a3, 1'b0, 3'd0, 16'h0000); mid();
        chk("t4_mem_rdy_alu", {31'd0, mem_ready}, 32'd0);
        end_cycle();
        set_in(1'b1, 1'b1, 3'd0, 16'hbad0, 1'b1, 3'd0, 16'hbad1); mid();
        chk("t4_full", {30'd0, alu_ready, mem_ready}, 32'd0);
        end_cycle();
        for (int i = 0; i < 4; i++) begin
            idle(1'b0); mid(); end_cycle();
        end
        idle(1'b0); mid();
        chk("t4_ready_back", {30'd0, alu_ready, mem_ready}, 32'd3);
        chk("t4_drained", exp_q.size(), 32'd0);
        end_cycle();

        // Reset discards three queued entries
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 3'(i), 16'hdea0 + 16'(i), 1'b0, 3'd0, 16'h0000); mid(); end_cycle();
        end
        idle(1'b1); reset = 1'b1; exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0; mcount = 0; a_ok = 0; m_ok = 0; pop_m = 0;
        idle(1'b0); ra = 3'd0; rb = 3'd1; mid();
        chk("t5_we", {31'd0, writeEnable}, 32'd0);
        chk("t5_hits", {30'd0, fwd_a_hit, fwd_b_hit}, 32'd0);
        end_cycle();
        for (int i = 0; i < 4; i++) begin
            idle(1'b0); mid(); end_cycle();
        end

        // Mixed pushes with hold toggling, across pointer wrap-around
        for (int i = 0; i < 8; i++) begin
            set_in(t_h[i], t_av[i], t_aa[i], t_ad[i], t_mv[i], t_ma[i], t_md[i]); mid(); end_cycle();
        end
        for (int i = 0; i < 8; i++) begin
            idle(1'b0); mid(); end_cycle();
        end
        chk("t6_drained", exp_q.size(), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t6_rf_r%0d", i), {16'd0, rf_act[i]}, {16'd0, rf_exp[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
